// File: rtl/mcu_capture_pkg.sv
// Shared types and constants for the MCU strip capture engine:
// FSM state encoding, CSR map, CTRL/STATUS bit positions and the fixed-point helper.
package mcu_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_t;

  localparam logic [10:0] CSR_CTRL   = 11'd0;
  localparam logic [10:0] CSR_STATUS = 11'd1;
  localparam logic [10:0] CSR_PIXCNT = 11'd2;

  localparam int unsigned CTRL_START_BIT = 8;
  localparam int unsigned CTRL_ABORT_BIT = 9;
  localparam int unsigned CTRL_IRQEN_BIT = 10;

  localparam int unsigned STAT_DONE_BIT      = 2;
  localparam int unsigned STAT_ERR_RANGE_BIT = 3;
  localparam int unsigned STAT_ERR_LOST_BIT  = 4;

  // Zero-extended sample shifted into an unsigned fixed-point word.
  function automatic logic [31:0] to_fixed(input logic [31:0] sample, input int unsigned frac_w);
    return sample << frac_w;
  endfunction

endpackage

// File: rtl/strip_buffer.sv
// Simple dual-port strip RAM: one write port, one registered read port, no reset
// on the storage or read register so it maps onto block RAM.
module strip_buffer #(
  parameter int unsigned DEPTH = 1792,
  parameter int unsigned AW    = 11,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/mcu_strip_capture.sv
// Captures one horizontal strip of BLKxBLK MCUs from the luma stream into a strip
// buffer and exposes buffer plus CTRL/STATUS/PIXCNT on an Avalon-MM slave.
module mcu_strip_capture
  import mcu_capture_pkg::*;
#(
  parameter int unsigned X0     = 208,
  parameter int unsigned Y0     = 128,
  parameter int unsigned WIN_W  = 224,
  parameter int unsigned WIN_H  = 224,
  parameter int unsigned BLK    = 8,
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned FRAC_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pix_valid,
  input  logic [10:0]      pix_x,
  input  logic [10:0]      pix_y,
  input  logic [PIX_W-1:0] pix_luma,
  input  logic [11:0]      addr,
  input  logic             rd_en,
  input  logic             wr_en,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int unsigned DEPTH  = WIN_W * BLK;
  localparam int unsigned NSTRIP = WIN_H / BLK;
  localparam int unsigned LB     = $clog2(BLK);
  localparam logic [10:0] X_LO     = 11'(X0);
  localparam logic [10:0] X_HI     = 11'(X0 + WIN_W - 1);
  localparam logic [10:0] COL_MASK = 11'(BLK - 1);

  cap_state_t       state;
  logic [7:0]       ctrl_strip, strip_q;
  logic             irq_en, done, err_range, err_lost;
  logic [11:0]      pixcnt;
  logic [10:0]      top_row, bot_row, dx, dy, widx;
  logic             in_x, in_y, last_px, accept, overrun;
  logic             wr_ctrl, wr_status, start_req, abort_req;
  logic [31:0]      csr_mux, csr_q;
  logic             rd_buf, rd_oob, buf_re;
  logic [PIX_W-1:0] buf_rdata;

  // Range tests compare before subtracting so coordinates left/above the window never wrap in.
  assign top_row = 11'(Y0) + ({3'b0, strip_q} << LB);
  assign bot_row = top_row + COL_MASK;
  assign in_x    = (pix_x >= X_LO) && (pix_x <= X_HI);
  assign in_y    = (pix_y >= top_row) && (pix_y <= bot_row);
  assign dx      = pix_x - X_LO;
  assign dy      = pix_y - top_row;
  assign widx    = ((dx >> LB) << (2 * LB)) | (dy << LB) | (dx & COL_MASK);
  assign last_px = (pix_x == X_HI) && (pix_y == bot_row);

  assign wr_ctrl   = wr_en && !addr[11] && (addr[10:0] == CSR_CTRL);
  assign wr_status = wr_en && !addr[11] && (addr[10:0] == CSR_STATUS);
  assign start_req = wr_ctrl && writedata[CTRL_START_BIT];
  assign abort_req = wr_ctrl && writedata[CTRL_ABORT_BIT];

  always_comb begin
    accept  = 1'b0;
    overrun = 1'b0;
    if (pix_valid && !abort_req) begin
      if (state == ST_ARMED)
        accept = (pix_x == X_LO) && (pix_y == top_row);
      else if (state == ST_CAPTURE) begin
        accept  = in_x && in_y;
        overrun = (pix_y > bot_row) || (pix_y < top_row);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      ctrl_strip <= '0;
      strip_q    <= '0;
      irq_en     <= 1'b0;
      done       <= 1'b0;
      err_range  <= 1'b0;
      err_lost   <= 1'b0;
      pixcnt     <= '0;
      irq        <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_strip <= writedata[7:0];
        irq_en     <= writedata[CTRL_IRQEN_BIT];
      end
      // W1C first so that a flag raised in the same cycle still lands.
      if (wr_status && writedata[STAT_DONE_BIT]) begin
        done      <= 1'b0;
        err_range <= 1'b0;
        err_lost  <= 1'b0;
      end
      if (accept) pixcnt <= pixcnt + 12'd1;
      if (abort_req) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (start_req) begin
              strip_q <= writedata[7:0];
              pixcnt  <= '0;
              if (32'(writedata[7:0]) >= NSTRIP) begin
                err_range <= 1'b1;
                done      <= 1'b1;
                state     <= ST_DONE;
              end else begin
                state <= ST_ARMED;
              end
            end
          end
          ST_ARMED: if (accept) state <= ST_CAPTURE;
          ST_CAPTURE: begin
            if (overrun) begin
              done     <= 1'b1;
              err_lost <= 1'b1;
              state    <= ST_DONE;
            end else if (accept && last_px) begin
              done <= 1'b1;
              if (pixcnt + 12'd1 != 12'(DEPTH)) err_lost <= 1'b1;
              state <= ST_DONE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
      irq <= done && irq_en;
    end
  end

  strip_buffer #(
    .DEPTH (DEPTH),
    .AW    (11),
    .DW    (PIX_W)
  ) u_buf (
    .clk   (clk),
    .we    (accept),
    .waddr (widx),
    .wdata (pix_luma),
    .re    (buf_re),
    .raddr (addr[10:0]),
    .rdata (buf_rdata)
  );

  assign buf_re = rd_en && addr[11] && (32'(addr[10:0]) < DEPTH);

  always_comb begin
    csr_mux = '0;
    case (addr[10:0])
      CSR_CTRL:   csr_mux = {21'b0, irq_en, 2'b0, ctrl_strip};
      CSR_STATUS: csr_mux = {16'b0, strip_q, 3'b0, err_lost, err_range, done, state};
      CSR_PIXCNT: csr_mux = {20'b0, pixcnt};
      default:    csr_mux = '0;
    endcase
  end

  // Select/flag registers hold with the RAM output so readdata stays put between reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_buf <= 1'b0;
      rd_oob <= 1'b0;
      csr_q  <= '0;
    end else if (rd_en) begin
      rd_buf <= addr[11];
      rd_oob <= (32'(addr[10:0]) >= DEPTH);
      csr_q  <= csr_mux;
    end
  end

  assign readdata = !rd_buf ? csr_q :
                    rd_oob  ? '0    : to_fixed(32'(buf_rdata), FRAC_W);

endmodule

// File: tb/tb_mcu_strip_capture.sv
// Directed bench for mcu_strip_capture: default instance plus a BLK=16 instance
// sharing the bus, each fed its own pixel-valid strobe.
module tb_mcu_strip_capture;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pv1 = 1'b0, pv2 = 1'b0;
  logic [10:0] px = '0, py = '0;
  logic [7:0]  pl = '0;
  logic [11:0] addr = '0;
  logic        rd_en = 1'b0, wr_en = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] rdata1, rdata2, d;
  logic        irq1, irq2;
  logic        sel2 = 1'b0;
  int unsigned n_checks = 0, n_errors = 0;
  int unsigned drop_x [3] = '{300, 301, 250};
  int unsigned drop_y [3] = '{145, 145, 150};
  logic        use_drops = 1'b0;

  always #5 clk = ~clk;

  mcu_strip_capture dut1 (
    .clk(clk), .reset_n(reset_n), .pix_valid(pv1), .pix_x(px), .pix_y(py), .pix_luma(pl),
    .addr(addr), .rd_en(rd_en), .wr_en(wr_en), .writedata(writedata),
    .readdata(rdata1), .irq(irq1)
  );

  mcu_strip_capture #(.X0(0), .Y0(0), .WIN_W(64), .BLK(16)) dut2 (
    .clk(clk), .reset_n(reset_n), .pix_valid(pv2), .pix_x(px), .pix_y(py), .pix_luma(pl),
    .addr(addr), .rd_en(rd_en), .wr_en(wr_en), .writedata(writedata),
    .readdata(rdata2), .irq(irq2)
  );

  function automatic logic [7:0] luma(input int unsigned x, input int unsigned y);
    return 8'(x * 7 + y * 13);
  endfunction

  function automatic logic [31:0] fx(input int unsigned x, input int unsigned y);
    logic [31:0] v;
    v = {24'b0, luma(x, y)};
    return v << 8;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [11:0] a, input logic [31:0] dat);
    addr = a; writedata = dat; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic bus_rd(input logic [11:0] a, output logic [31:0] dat);
    addr = a; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    dat = sel2 ? rdata2 : rdata1;
  endtask

  task automatic stream(input int unsigned y0, input int unsigned y1,
                        input int unsigned x0, input int unsigned x1);
    for (int unsigned y = y0; y <= y1; y++) begin
      for (int unsigned x = x0; x <= x1; x++) begin
        logic drop;
        drop = 1'b0;
        if (use_drops)
          for (int unsigned k = 0; k < 3; k++)
            if (drop_x[k] == x && drop_y[k] == y) drop = 1'b1;
        px = 11'(x); py = 11'(y); pl = luma(x, y);
        if (sel2) pv2 = !drop; else pv1 = !drop;
        tick();
      end
    end
    pv1 = 1'b0; pv2 = 1'b0;
    tick();
  endtask

  localparam logic [31:0] IRQ_EN = 32'h400;
  localparam logic [31:0] START  = 32'h100;
  localparam logic [31:0] ABORT  = 32'h200;

  initial begin
    repeat (3) tick();
    check_eq("rst_readdata", rdata1, 32'h0);
    check_eq("rst_irq", {31'b0, irq1}, 32'h0);
    reset_n = 1'b1;
    tick();
    bus_rd(12'h001, d); check_eq("rst_status", d, 32'h0);
    bus_rd(12'h002, d); check_eq("rst_pixcnt", d, 32'h0);
    bus_rd(12'h000, d); check_eq("rst_ctrl", d, 32'h0);

    // strip 0, full capture
    bus_wr(12'h000, IRQ_EN | START | 32'd0);
    bus_rd(12'h001, d); check_eq("s0_armed", d, 32'h1);
    stream(127, 137, 200, 439);
    bus_rd(12'h001, d); check_eq("s0_status", d, 32'h7);
    bus_rd(12'h002, d); check_eq("s0_pixcnt", d, 32'd1792);
    check_eq("s0_irq", {31'b0, irq1}, 32'h1);
    bus_rd(12'h800, d); check_eq("s0_word0", d, fx(208, 128));
    bus_rd(12'h800 + 12'd1791, d); check_eq("s0_word1791", d, fx(431, 135));
    bus_rd(12'h800 + 12'd346, d); check_eq("s0_word346", d, fx(250, 131));
    bus_rd(12'h800 + 12'd1792, d); check_eq("s0_oob", d, 32'h0);
    bus_rd(12'h000, d); check_eq("s0_ctrl", d, 32'h400);
    bus_wr(12'h001, 32'h4);
    bus_rd(12'h001, d); check_eq("w1c_status", d, 32'h3);
    check_eq("w1c_irq", {31'b0, irq1}, 32'h0);

    // strip 27: last valid strip
    bus_wr(12'h000, IRQ_EN | START | 32'd27);
    stream(343, 352, 206, 433);
    bus_rd(12'h001, d); check_eq("s27_status", d, 32'h1B07);
    bus_rd(12'h002, d); check_eq("s27_pixcnt", d, 32'd1792);
    bus_rd(12'h800, d); check_eq("s27_word0", d, fx(208, 344));
    bus_rd(12'h800 + 12'd1791, d); check_eq("s27_last", d, fx(431, 351));
    bus_wr(12'h001, 32'h4);

    // strip 28: out of range
    bus_wr(12'h000, IRQ_EN | START | 32'd28);
    bus_rd(12'h001, d); check_eq("s28_status", d, 32'h1C0F);
    bus_rd(12'h800, d); check_eq("s28_nowrite", d, fx(208, 344));
    bus_wr(12'h001, 32'h4);
    bus_rd(12'h001, d); check_eq("s28_w1c", d, 32'h1C03);

    // strip 2 with three dropped pixels
    bus_wr(12'h000, IRQ_EN | START | 32'd2);
    use_drops = 1'b1;
    stream(143, 152, 206, 433);
    use_drops = 1'b0;
    bus_rd(12'h001, d); check_eq("drop_status", d, 32'h0217);
    bus_rd(12'h002, d); check_eq("drop_pixcnt", d, 32'd1789);

    // abort mid-capture, flags persist
    bus_wr(12'h000, IRQ_EN | START | 32'd3);
    bus_rd(12'h001, d); check_eq("s3_armed", d, 32'h0315);
    stream(152, 153, 206, 433);
    bus_rd(12'h001, d); check_eq("s3_capture", d, 32'h0316);
    bus_wr(12'h000, IRQ_EN | ABORT);
    bus_rd(12'h001, d); check_eq("abort_idle", d, 32'h0314);
    bus_wr(12'h000, IRQ_EN | START | 32'd5);
    bus_rd(12'h001, d); check_eq("s5_armed", d, 32'h0515);
    bus_wr(12'h000, IRQ_EN | START | 32'd7);
    bus_rd(12'h001, d); check_eq("start_ignored", d, 32'h0515);
    bus_wr(12'h000, IRQ_EN | START | ABORT | 32'd7);
    bus_rd(12'h001, d); check_eq("abort_wins", d, 32'h0514);
    bus_wr(12'h000, IRQ_EN | START | 32'd5);
    stream(167, 176, 206, 433);
    bus_rd(12'h001, d); check_eq("s5_status", d, 32'h0517);
    bus_rd(12'h002, d); check_eq("s5_pixcnt", d, 32'd1792);
    bus_rd(12'h800, d); check_eq("s5_word0", d, fx(208, 168));
    bus_rd(12'h800 + 12'd1791, d); check_eq("s5_last", d, fx(431, 175));
    bus_wr(12'h001, 32'h4);
    bus_rd(12'h001, d); check_eq("s5_w1c", d, 32'h0503);

    // overrun past the strip bottom
    bus_wr(12'h000, IRQ_EN | START | 32'd6);
    stream(176, 177, 208, 431);
    stream(184, 184, 208, 208);
    bus_rd(12'h001, d); check_eq("ovr_status", d, 32'h0617);
    bus_rd(12'h002, d); check_eq("ovr_pixcnt", d, 32'd448);
    bus_wr(12'h001, 32'h4);

    // reset in the middle of a capture
    bus_wr(12'h000, IRQ_EN | START | 32'd4);
    stream(160, 160, 208, 300);
    bus_rd(12'h001, d); check_eq("s4_capture", d, 32'h0402);
    reset_n = 1'b0;
    #2;
    check_eq("mid_rst_readdata", rdata1, 32'h0);
    check_eq("mid_rst_irq", {31'b0, irq1}, 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    bus_rd(12'h001, d); check_eq("post_rst_status", d, 32'h0);
    bus_rd(12'h000, d); check_eq("post_rst_ctrl", d, 32'h0);
    bus_wr(12'h000, IRQ_EN | START | 32'd1);
    stream(135, 144, 206, 433);
    bus_rd(12'h001, d); check_eq("s1_status", d, 32'h0107);
    bus_rd(12'h002, d); check_eq("s1_pixcnt", d, 32'd1792);
    bus_rd(12'h800, d); check_eq("s1_word0", d, fx(208, 136));
    check_eq("s1_irq", {31'b0, irq1}, 32'h1);

    // BLK=16, WIN_W=64, X0=Y0=0 instance: strip 1 = rows 16..31
    sel2 = 1'b1;
    bus_wr(12'h000, ABORT);
    bus_wr(12'h000, IRQ_EN | START | 32'd1);
    stream(15, 32, 0, 70);
    bus_rd(12'h001, d); check_eq("b16_status", d, 32'h0107);
    bus_rd(12'h002, d); check_eq("b16_pixcnt", d, 32'd1024);
    bus_rd(12'h800, d); check_eq("b16_word0", d, fx(0, 16));
    bus_rd(12'h800 + 12'd1023, d); check_eq("b16_word1023", d, fx(63, 31));
    bus_rd(12'h800 + 12'd291, d); check_eq("b16_word291", d, fx(19, 18));
    bus_rd(12'h800 + 12'd1024, d); check_eq("b16_oob", d, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mcu_strip_capture.md
# mcu_strip_capture

Parametrised capture engine that snoops the clk-domain luma pixel stream (after the slow-to-fast synchroniser), collects one horizontal strip of BLK×BLK MCUs from a configurable capture window into an on-chip buffer, and exposes the buffer plus control/status registers on an Avalon-MM slave. It sits between the VGA-side synchroniser and the DCT/quantisation path. It replaces ad-hoc per-MCU registers with an addressable, software-sequenced strip buffer that reports errors.

## Interface
- X0, 208: left column of the capture window (inclusive).
- Y0, 128: top row of the capture window (inclusive).
- WIN_W, 224: window width in pixels; must be a multiple of BLK.
- WIN_H, 224: window height in pixels; must be a multiple of BLK.
- BLK, 8: MCU edge length; power of two.
- PIX_W, 8: luma sample width.
- FRAC_W, 8: fractional bits of the returned fixed-point sample.
- clk  in  1  system clock (100 MHz).
- reset_n  in  1  asynchronous active-low reset.
- pix_valid  in  1  pix_* fields valid this cycle; one new pixel per assertion.
- pix_x  in  11  pixel column.
- pix_y  in  11  pixel row.
- pix_luma  in  PIX_W  luma sample.
- addr  in  12  Avalon word address.
- rd_en  in  1  Avalon read.
- wr_en  in  1  Avalon write.
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data; fixed read latency 1.
- irq  out  1  level; high while STATUS.done=1 and CTRL.irq_en=1.

## Operation
- Register map (addr[11]=0): 0 CTRL (W: [7:0] strip, [8] start, [9] abort, [10] irq_en; R: strip and irq_en, start/abort read 0); 1 STATUS (R: [1:0] state, [2] done, [3] err_range, [4] err_lost, [15:8] latched strip); 2 PIXCNT (R: pixels captured in the current/last strip). A write to STATUS with bit 2 set clears done, err_range, and err_lost (W1C).
- Buffer (addr[11]=1): word index = mcu*BLK*BLK + row*BLK + col, where mcu = (pix_x−X0)/BLK, row = pix_y−(Y0+BLK*strip), col = (pix_x−X0)%BLK. The read value is the luma zero-extended and shifted left by FRAC_W. Indices ≥ WIN_W*BLK read 0.
- FSM IDLE→ARMED: on a start write while in IDLE or DONE. Strip number is latched. If strip ≥ WIN_H/BLK, set err_range and go to DONE with done=1.
- ARMED→CAPTURE: on pix_valid with pix_x==X0 and pix_y==Y0+BLK*strip. That pixel is written and counted.
- CAPTURE: every pix_valid pixel inside the strip rectangle is written and counted. Pixels outside the rectangle are ignored.
- CAPTURE→DONE: on the pixel (X0+WIN_W−1, Y0+BLK*strip+BLK−1). Set done. If PIXCNT ≠ WIN_W*BLK, set err_lost.
- CAPTURE→DONE (overrun): on a pix_valid with pix_y > strip bottom row, or on pix_y < strip top row (frame wrap). Set done and err_lost.
- Abort write in any state: go to IDLE. Flags are unchanged. Abort wins over a simultaneous start.
- A start write while in ARMED or CAPTURE is ignored.
- All arithmetic is unsigned 11-bit. Coordinates below X0/Y0 must not wrap into the window: compare before subtracting.

## Timing
- Reset values: state IDLE, all flags 0, PIXCNT 0, CTRL 0, readdata 0, irq 0. Buffer contents are not reset (undefined).
- Reset asserted mid-capture returns the block to IDLE immediately; the next start behaves as after a cold reset.
- Buffer write is in the same cycle as the accepted pixel. A CSR read reflects a pixel accepted in cycle N from cycle N+1.
- Reads have latency 1: readdata is valid the cycle after rd_en and holds its value until the next read. A read and a write in the same cycle are both serviced.
- A buffer read during CAPTURE returns whatever is stored; there is no stall and no waitrequest.
- irq follows done with 1 cycle of latency.

## Structure
- Package mcu_capture_pkg holds: the state enum (IDLE=0, ARMED=1, CAPTURE=2, DONE=3), CSR address constants, CTRL/STATUS bit positions, and the fixed-point helper function.
- Sub-module strip_buffer: simple dual-port RAM, WIN_W*BLK entries × PIX_W bits, one write port and one registered read port. It must infer block RAM.
- Top level contains the FSM, the coordinate/index calculation, the CSRs, and the readdata mux.

## Test plan
- Default parameters, start strip 0, full frame stream → done=1, PIXCNT=1792, no errors. Reading word 0x800 returns luma(208,128)<<8. Word 0x800+1791 returns luma(431,135)<<8.
- Start strip 27 → capture rows 344–351. Start strip 28 → immediate DONE with err_range=1; no buffer writes.
- Drop 3 pix_valid pulses inside the strip → done=1, err_lost=1, PIXCNT=1789.
- Abort during CAPTURE, then restart strip 5 → IDLE, then ARMED. The second capture completes cleanly and the earlier flags persist until W1C.
- Assert reset_n low mid-CAPTURE → STATUS=0, readdata=0, irq=0. A subsequent start on strip 1 succeeds.
- Parameters BLK=16, WIN_W=64, X0=0, Y0=0: strip 1 captures rows 16–31. Word index mapping is verified for mcu 3, row 15, col 15 (index 1023).
